// File: rtl/tmp1075_pkg.sv
// Shared definitions for the TMP1075N command sequencer.
//   state_t      : sequencer FSM states
//   REG_TEMP/CFG : TMP1075N register pointers
//   CFG_*_DEF    : default configuration bytes written to REG_CFG
//   is_cmd()     : true for the single-cycle states that fire i2c_exec
package tmp1075_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG1,
    ST_CFG2,
    ST_RD,
    ST_WAIT,
    ST_POLL,
    ST_FAULT
  } state_t;

  localparam logic [7:0] REG_TEMP   = 8'h00;
  localparam logic [7:0] REG_CFG    = 8'h01;

  localparam logic [7:0] CFG_HI_DEF = 8'h61;
  localparam logic [7:0] CFG_LO_DEF = 8'hAB;

  function automatic logic is_cmd(input state_t s);
    return (s == ST_CFG1) || (s == ST_CFG2) || (s == ST_RD);
  endfunction

endpackage

// File: rtl/tmp1075_if.sv
// Command/response bundle between the sequencer and i2c_dri.
//   master : sequencer side (drives exec, bit_ctrl, rh_wl, addr, data_w)
//   slave  : i2c_dri side   (drives data_r, done, ack)
interface tmp1075_if;

  logic        i2c_exec;
  logic        bit_ctrl;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r;
  logic        i2c_done;
  logic        i2c_ack;

  modport master (
    output i2c_exec, bit_ctrl, i2c_rh_wl, i2c_addr, i2c_data_w,
    input  i2c_data_r, i2c_done, i2c_ack
  );

  modport slave (
    input  i2c_exec, bit_ctrl, i2c_rh_wl, i2c_addr, i2c_data_w,
    output i2c_data_r, i2c_done, i2c_ack
  );

endinterface

// File: rtl/tmp1075_ctrl_temp_alarm.sv
// Signed hysteresis comparator for the temperature alarm.
//   dri_clk, sys_rst_n : clock / async active-low reset
//   load               : new temperature sample accepted this cycle
//   temp_in            : signed sample, 1 degC/LSB
//   temp_valid         : one-cycle pulse the cycle after load
//   over_temp          : set at >= T_HIGH, cleared at <= T_LOW, else held
module temp_alarm #(
  parameter logic signed [7:0] T_HIGH = 8'sd60,
  parameter logic signed [7:0] T_LOW  = 8'sd55
) (
  input  logic              dri_clk,
  input  logic              sys_rst_n,
  input  logic              load,
  input  logic signed [7:0] temp_in,
  output logic              temp_valid,
  output logic              over_temp
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge dri_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      temp_valid <= 1'b0;
      over_temp  <= 1'b0;
    end else begin
      temp_valid <= load;
      // Both operands are signed, so 0xF6 compares as -10 rather than 246.
      if (load) begin
        if (temp_in >= T_HIGH) begin
          over_temp <= 1'b1;
        end else if (temp_in <= T_LOW) begin
          over_temp <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/tmp1075_ctrl.sv
// TMP1075N command sequencer sitting upstream of i2c_dri.
// After enable it writes CFG_HI then CFG_LO to register 0x01, then reads
// register 0x00 every POLL_CYC cycles and publishes the signed MSB with a
// hysteretic alarm. NACKs and timeouts are retried up to MAX_RETRY times.
//   dri_clk, sys_rst_n : clock / async active-low reset
//   enable             : 1 = run, 0 = stop at next transaction boundary
//   bus                : i2c_dri command/response interface (master side)
//   temp_c             : signed temperature, 1 degC/LSB
//   temp_valid         : one-cycle pulse when temp_c updates
//   over_temp          : hysteretic alarm
//   busy               : sequencer active (not IDLE/FAULT)
//   fault              : retries exhausted; cleared by enable = 0
module tmp1075_ctrl
  import tmp1075_pkg::*;
#(
  parameter logic        [7:0]  CFG_HI      = CFG_HI_DEF,
  parameter logic        [7:0]  CFG_LO      = CFG_LO_DEF,
  parameter logic        [19:0] POLL_CYC    = 20'd250_000,
  parameter logic        [15:0] TIMEOUT_CYC = 16'd4_000,
  parameter logic        [1:0]  MAX_RETRY   = 2'd2,
  parameter logic signed [7:0]  T_HIGH      = 8'sd60,
  parameter logic signed [7:0]  T_LOW       = 8'sd55
) (
  input  logic        dri_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  tmp1075_if.master   bus,
  output logic [7:0]  temp_c,
  output logic        temp_valid,
  output logic        over_temp,
  output logic        busy,
  output logic        fault
);

  state_t      state_q, state_d;
  state_t      cmd_q;      // command currently owned by the driver
  logic [1:0]  retry_q;
  logic        rec_q;      // recovering from a timeout: wait for done or a second window
  logic [15:0] tmr_q;
  logic [19:0] poll_q;

  logic        retry_inc, retry_clr, rec_set, rd_ok;
  logic        tmr_exp, poll_exp;

  assign tmr_exp  = (tmr_q == TIMEOUT_CYC - 16'd1);
  assign poll_exp = (poll_q == POLL_CYC - 20'd1);

  function automatic state_t next_cmd(input state_t c);
    case (c)
      ST_CFG1: return ST_CFG2;
      ST_CFG2: return ST_RD;
      default: return ST_POLL;
    endcase
  endfunction

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    rec_set   = 1'b0;
    rd_ok     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        retry_clr = 1'b1;
        if (enable) state_d = ST_CFG1;
      end
      ST_CFG1, ST_CFG2, ST_RD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rec_q) begin
          // Driver state is known again (done) or assumed idle (second window).
          if (bus.i2c_done || tmr_exp) state_d = enable ? cmd_q : ST_IDLE;
        end else if (bus.i2c_done && !bus.i2c_ack) begin
          retry_clr = 1'b1;
          rd_ok     = (cmd_q == ST_RD);
          state_d   = enable ? next_cmd(cmd_q) : ST_IDLE;
        end else if (bus.i2c_done || tmr_exp) begin
          if (retry_q < MAX_RETRY) begin
            retry_inc = 1'b1;
            if (bus.i2c_done) state_d = enable ? cmd_q : ST_IDLE;
            else              rec_set = 1'b1;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_POLL: begin
        if (!enable)       state_d = ST_IDLE;
        else if (poll_exp) state_d = ST_RD;
      end
      ST_FAULT: if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: only control registers exist here (no memory arrays), so every
  // flop is async-reset to a defined value.
  always_ff @(posedge dri_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= ST_IDLE;
      cmd_q          <= ST_IDLE;
      retry_q        <= '0;
      rec_q          <= 1'b0;
      tmr_q          <= '0;
      poll_q         <= '0;
      bus.i2c_exec   <= 1'b0;
      bus.i2c_rh_wl  <= 1'b0;
      bus.i2c_addr   <= '0;
      bus.i2c_data_w <= '0;
      temp_c         <= '0;
    end else begin
      state_q <= state_d;

      // Command fields are loaded on entry to a command state, so they are
      // valid in the exec cycle and held through WAIT until i2c_done.
      bus.i2c_exec <= is_cmd(state_d);
      if (is_cmd(state_d)) cmd_q <= state_d;
      case (state_d)
        ST_CFG1: begin
          bus.i2c_rh_wl  <= 1'b0;
          bus.i2c_addr   <= {8'h00, REG_CFG};
          bus.i2c_data_w <= CFG_HI;
        end
        ST_CFG2: begin
          bus.i2c_rh_wl  <= 1'b0;
          bus.i2c_addr   <= {8'h00, REG_CFG};
          bus.i2c_data_w <= CFG_LO;
        end
        ST_RD: begin
          bus.i2c_rh_wl  <= 1'b1;
          bus.i2c_addr   <= {8'h00, REG_TEMP};
          bus.i2c_data_w <= '0;
        end
        default: ;
      endcase

      if (retry_clr)      retry_q <= '0;
      else if (retry_inc) retry_q <= retry_q + 2'd1;

      if (rec_set)                 rec_q <= 1'b1;
      else if (state_d != ST_WAIT) rec_q <= 1'b0;

      // Timer restarts on entry to WAIT and again at the start of recovery.
      if (state_q == ST_WAIT && !rec_set) tmr_q <= tmr_q + 16'd1;
      else                                tmr_q <= '0;

      if (state_q == ST_POLL && state_d == ST_POLL) poll_q <= poll_q + 20'd1;
      else                                          poll_q <= '0;

      if (rd_ok) temp_c <= bus.i2c_data_r;
    end
  end

  assign bus.bit_ctrl = 1'b0;
  assign busy  = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign fault = (state_q == ST_FAULT);

  temp_alarm #(
    .T_HIGH (T_HIGH),
    .T_LOW  (T_LOW)
  ) u_temp_alarm (
    .dri_clk    (dri_clk),
    .sys_rst_n  (sys_rst_n),
    .load       (rd_ok),
    .temp_in    ($signed(bus.i2c_data_r)),
    .temp_valid (temp_valid),
    .over_temp  (over_temp)
  );

endmodule

// File: tb/tb_tmp1075_ctrl.sv
// Self-checking bench for tmp1075_ctrl with a behavioural TMP1075N/i2c_dri
// model. Expected commands and temperatures are queued and compared by
// monitors as the DUT produces exec pulses and temp_valid pulses.
module tb_tmp1075_ctrl;
  import tmp1075_pkg::*;

  localparam int          LAT  = 4;
  localparam logic [19:0] POLL = 20'd60;
  localparam logic [15:0] TMO  = 16'd30;

  typedef struct {
    logic        rh;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        chk_data;
  } cmd_t;

  logic       dri_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       enable    = 1'b0;
  logic [7:0] temp_c;
  logic       temp_valid, over_temp, busy, fault;

  tmp1075_if bus();

  tmp1075_ctrl #(
    .POLL_CYC    (POLL),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .dri_clk    (dri_clk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .bus        (bus),
    .temp_c     (temp_c),
    .temp_valid (temp_valid),
    .over_temp  (over_temp),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 dri_clk = ~dri_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exec_cnt = 0;
  int tv_cnt   = 0;
  int exec_cyc_q[$];
  cmd_t       exp_cmd_q[$];
  logic [7:0] exp_temp_q[$];
  logic [7:0] rd_q[$];
  int   nack_left = 0;
  logic silent    = 1'b0;

  always @(posedge dri_clk) cyc++;

  // ---------------- i2c_dri + TMP1075N model ----------------
  initial begin : model
    logic        pend;
    int          cd;
    cmd_t        cap;
    logic [7:0]  v;
    bus.i2c_done   = 1'b0;
    bus.i2c_ack    = 1'b0;
    bus.i2c_data_r = 8'h00;
    pend = 1'b0;
    cd   = 0;
    forever begin
      @(posedge dri_clk); #1;
      bus.i2c_done = 1'b0;
      bus.i2c_ack  = 1'b0;
      if (!sys_rst_n) pend = 1'b0;
      if (pend) begin
        if (cd == 0) begin
          pend = 1'b0;
          total++;
          if (bus.i2c_rh_wl !== cap.rh || bus.i2c_addr !== cap.addr ||
              bus.i2c_data_w !== cap.data) begin
            bad++;
            $display("FAIL cmd_hold: at done rh=%0b addr=%h data=%h, required rh=%0b addr=%h data=%h",
                     bus.i2c_rh_wl, bus.i2c_addr, bus.i2c_data_w, cap.rh, cap.addr, cap.data);
          end
          bus.i2c_done = 1'b1;
          if (nack_left > 0) begin
            bus.i2c_ack = 1'b1;
            nack_left--;
          end else if (cap.rh) begin
            v = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h19;
            bus.i2c_data_r = v;
            exp_temp_q.push_back(v);
          end
        end else begin
          cd--;
        end
      end
      if (sys_rst_n && bus.i2c_exec === 1'b1 && !silent) begin
        pend     = 1'b1;
        cd       = LAT - 1;
        cap.rh   = bus.i2c_rh_wl;
        cap.addr = bus.i2c_addr;
        cap.data = bus.i2c_data_w;
      end
    end
  end

  // ---------------- monitors ----------------
  cmd_t       mon_e;
  logic [7:0] mon_t;
  always @(negedge dri_clk) begin
    if (sys_rst_n && bus.i2c_exec === 1'b1) begin
      exec_cnt++;
      exec_cyc_q.push_back(cyc);
      total++;
      if (exp_cmd_q.size() == 0) begin
        bad++;
        $display("FAIL exec_unexpected: got rh=%0b addr=%h data=%h, required no exec",
                 bus.i2c_rh_wl, bus.i2c_addr, bus.i2c_data_w);
      end else begin
        mon_e = exp_cmd_q.pop_front();
        if (bus.i2c_rh_wl !== mon_e.rh || bus.i2c_addr !== mon_e.addr ||
            bus.bit_ctrl !== 1'b0 || (mon_e.chk_data && bus.i2c_data_w !== mon_e.data)) begin
          bad++;
          $display("FAIL exec_cmd: got rh=%0b addr=%h data=%h bit_ctrl=%0b, required rh=%0b addr=%h data=%h bit_ctrl=0",
                   bus.i2c_rh_wl, bus.i2c_addr, bus.i2c_data_w, bus.bit_ctrl,
                   mon_e.rh, mon_e.addr, mon_e.data);
        end
      end
    end
    if (sys_rst_n && temp_valid === 1'b1) begin
      tv_cnt++;
      total++;
      if (exp_temp_q.size() == 0) begin
        bad++;
        $display("FAIL temp_unexpected: temp_valid with temp_c=%0d, required no pulse", $signed(temp_c));
      end else begin
        mon_t = exp_temp_q.pop_front();
        if (temp_c !== mon_t) begin
          bad++;
          $display("FAIL temp_c: got %0d, required %0d", $signed(temp_c), $signed(mon_t));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic cmd_t mk(input logic rh, input logic [15:0] a, input logic [7:0] d,
                              input logic cd);
    cmd_t c;
    c.rh = rh; c.addr = a; c.data = d; c.chk_data = cd;
    return c;
  endfunction

  task automatic push_cfg1();
    exp_cmd_q.push_back(mk(1'b0, 16'h0001, 8'h61, 1'b1));
  endtask

  task automatic push_seq();
    push_cfg1();
    exp_cmd_q.push_back(mk(1'b0, 16'h0001, 8'hAB, 1'b1));
    exp_cmd_q.push_back(mk(1'b1, 16'h0000, 8'h00, 1'b0));
  endtask

  task automatic push_rd();
    exp_cmd_q.push_back(mk(1'b1, 16'h0000, 8'h00, 1'b0));
  endtask

  task automatic apply_reset();
    enable    = 1'b0;
    sys_rst_n = 1'b0;
    repeat (10) @(negedge dri_clk);
    exp_cmd_q.delete();
    exp_temp_q.delete();
    rd_q.delete();
    exec_cyc_q.delete();
    nack_left = 0;
    silent    = 1'b0;
    exec_cnt  = 0;
    tv_cnt    = 0;
    sys_rst_n = 1'b1;
    repeat (2) @(negedge dri_clk);
  endtask

  task automatic wait_tv(input int n, input string tag);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge dri_clk); #1;
      if (tv_cnt >= n) break;
    end
    total++;
    if (tv_cnt < n) begin
      bad++;
      $display("FAIL %s_wait_tv: got %0d pulses, required %0d", tag, tv_cnt, n);
    end
  endtask

  task automatic wait_fault(input string tag);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge dri_clk); #1;
      if (fault === 1'b1) break;
    end
    total++;
    if (fault !== 1'b1) begin
      bad++;
      $display("FAIL %s_fault: got %b, required 1", tag, fault);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    total++;
    if ({bus.i2c_exec, bus.bit_ctrl, bus.i2c_rh_wl, bus.i2c_addr, bus.i2c_data_w} !== 27'd0) begin
      bad++;
      $display("FAIL reset_bus: got exec=%b rh=%b addr=%h data=%h, required all 0",
               bus.i2c_exec, bus.i2c_rh_wl, bus.i2c_addr, bus.i2c_data_w);
    end
    total++;
    if ({temp_c, temp_valid, over_temp, busy, fault} !== 12'd0) begin
      bad++;
      $display("FAIL reset_status: got temp=%h tv=%b ot=%b busy=%b fault=%b, required all 0",
               temp_c, temp_valid, over_temp, busy, fault);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    push_seq();
    rd_q.push_back(8'h19);
    enable = 1'b1;
    wait_tv(1, "basic");
    @(negedge dri_clk); #1;
    total++;
    if (temp_valid !== 1'b0 || tv_cnt != 1) begin
      bad++;
      $display("FAIL basic_tv_pulse: got tv=%b count=%0d, required 0 and 1", temp_valid, tv_cnt);
    end
    total++;
    if (over_temp !== 1'b0 || busy !== 1'b1 || fault !== 1'b0) begin
      bad++;
      $display("FAIL basic_status: got ot=%b busy=%b fault=%b, required 0 1 0", over_temp, busy, fault);
    end
    enable = 1'b0;
    repeat (2) @(negedge dri_clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_hysteresis();
    logic [7:0] vals [4] = '{8'h3C, 8'h3A, 8'h37, 8'hF6};
    logic       exp_ot [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    push_seq();
    for (int i = 0; i < 4; i++) rd_q.push_back(vals[i]);
    for (int i = 1; i < 4; i++) push_rd();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tv(i + 1, "hyst");
      @(negedge dri_clk); #1;
      total++;
      if (over_temp !== exp_ot[i]) begin
        bad++;
        $display("FAIL hyst_over_temp[%0d]: got %b, required %b (temp %0d)",
                 i, over_temp, exp_ot[i], $signed(vals[i]));
      end
    end
    enable = 1'b0;
    repeat (2) @(negedge dri_clk);
  endtask

  task automatic test_nack_retry();
    apply_reset();
    nack_left = 2;
    push_cfg1();
    push_cfg1();
    push_seq();
    rd_q.push_back(8'h1E);
    enable = 1'b1;
    wait_tv(1, "retry");
    total++;
    if (exec_cnt != 5 || fault !== 1'b0) begin
      bad++;
      $display("FAIL retry_count: got execs=%0d fault=%b, required 5 and 0", exec_cnt, fault);
    end
    enable = 1'b0;
    repeat (2) @(negedge dri_clk);
  endtask

  task automatic test_nack_fault();
    apply_reset();
    nack_left = 3;
    push_cfg1(); push_cfg1(); push_cfg1();
    enable = 1'b1;
    wait_fault("nack");
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL nack_busy: got %b, required 0", busy);
    end
    repeat (200) @(negedge dri_clk); #1;
    total++;
    if (exec_cnt != 3 || fault !== 1'b1) begin
      bad++;
      $display("FAIL nack_no_exec: got execs=%0d fault=%b, required 3 and 1", exec_cnt, fault);
    end
    enable = 1'b0;
    repeat (2) @(negedge dri_clk); #1;
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL nack_fault_clear: got %b, required 0", fault);
    end
    push_seq();
    rd_q.push_back(8'h14);
    enable = 1'b1;
    wait_tv(1, "nack_restart");
    total++;
    if (exec_cnt != 6) begin
      bad++;
      $display("FAIL nack_restart_execs: got %0d, required 6", exec_cnt);
    end
    enable = 1'b0;
    repeat (2) @(negedge dri_clk);
  endtask

  task automatic test_timeout_fault();
    int gap;
    apply_reset();
    silent = 1'b1;
    push_cfg1(); push_cfg1(); push_cfg1();
    enable = 1'b1;
    wait_fault("timeout");
    total++;
    if (busy !== 1'b0 || exec_cnt != 3) begin
      bad++;
      $display("FAIL timeout_state: got busy=%b execs=%0d, required 0 and 3", busy, exec_cnt);
    end
    gap = (exec_cyc_q.size() >= 2) ? exec_cyc_q[1] - exec_cyc_q[0] : 0;
    total++;
    if (gap < 2 * int'(TMO)) begin
      bad++;
      $display("FAIL timeout_retry_gap: got %0d cycles, required >= %0d", gap, 2 * int'(TMO));
    end
    silent = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge dri_clk);
    push_seq();
    rd_q.push_back(8'h2D);
    enable = 1'b1;
    wait_tv(1, "timeout_restart");
    enable = 1'b0;
    repeat (2) @(negedge dri_clk);
  endtask

  task automatic test_disable_mid_read();
    int k;
    int snap;
    apply_reset();
    push_seq();
    rd_q.push_back(8'h2A);
    enable = 1'b1;
    for (k = 0; k < 500; k++) begin
      @(negedge dri_clk); #1;
      if (bus.i2c_exec === 1'b1 && bus.i2c_rh_wl === 1'b1) break;
    end
    @(negedge dri_clk); #1;
    enable = 1'b0;
    wait_tv(1, "mid_read");
    @(negedge dri_clk); #1;
    total++;
    if (busy !== 1'b0 || temp_c !== 8'h2A) begin
      bad++;
      $display("FAIL mid_read_idle: got busy=%b temp=%0d, required 0 and 42", busy, $signed(temp_c));
    end
    snap = exec_cnt;
    repeat (2 * int'(POLL)) @(negedge dri_clk); #1;
    total++;
    if (exec_cnt != snap) begin
      bad++;
      $display("FAIL mid_read_quiet: got %0d new execs, required 0", exec_cnt - snap);
    end
  endtask

  task automatic test_reset_mid_wait();
    int k;
    apply_reset();
    push_cfg1();
    enable = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge dri_clk); #1;
      if (bus.i2c_exec === 1'b1) break;
    end
    @(negedge dri_clk); #1;
    total++;
    if (busy !== 1'b1 || bus.i2c_addr !== 16'h0001) begin
      bad++;
      $display("FAIL rst_wait_pre: got busy=%b addr=%h, required 1 and 0001", busy, bus.i2c_addr);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    total++;
    if ({bus.i2c_exec, bus.i2c_rh_wl, bus.i2c_addr, bus.i2c_data_w, busy, fault, temp_valid} !== 29'd0) begin
      bad++;
      $display("FAIL rst_async: got exec=%b addr=%h data=%h busy=%b, required all 0",
               bus.i2c_exec, bus.i2c_addr, bus.i2c_data_w, busy);
    end
    enable = 1'b0;
    repeat (5) @(negedge dri_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hysteresis();
    test_nack_retry();
    test_nack_fault();
    test_timeout_fault();
    test_disable_mid_read();
    test_reset_mid_wait();
    repeat (5) @(negedge dri_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
